// File: rtl/serial_frame_deserializer_if.sv
// Handshake and data bundle between the frame deserializer and its
// surroundings. The master side drives the serial stream, the start
// request and the transmitter's ready; the slave side is the deserializer.
interface serial_frame_deserializer_if #(
    parameter int DATA_W = 8
);
    localparam int CW = $clog2(DATA_W + 1);

    logic              serial_in;
    logic              rise;
    logic              tx_ready;
    logic              wake_transmitter;
    logic [DATA_W-1:0] pout;
    logic [CW-1:0]     bit_count;
    logic              busy;
    logic              overrun;

    modport master (
        output serial_in,
        output rise,
        output tx_ready,
        input  wake_transmitter,
        input  pout,
        input  bit_count,
        input  busy,
        input  overrun
    );

    modport slave (
        input  serial_in,
        input  rise,
        input  tx_ready,
        output wake_transmitter,
        output pout,
        output bit_count,
        output busy,
        output overrun
    );
endinterface

// File: rtl/serial_frame_deserializer.sv
// Serial-to-parallel frame receiver. A start request opens a frame, an
// optional MSB-first length header selects how many payload bits follow,
// and the completed right-justified word is held with wake_transmitter
// asserted until the transmitter signals tx_ready. Start requests that
// arrive while a frame is open are dropped and latched into a sticky
// overrun flag.
module serial_frame_deserializer #(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1,
    parameter int VAR_LEN   = 0,
    parameter int LEN_W     = 4
) (
    input logic                      clk,
    input logic                      rst,
    serial_frame_deserializer_if.slave bus
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam int HW = (LEN_W > 1) ? $clog2(LEN_W) : 1;
    localparam int TW = (LEN_W > CW) ? LEN_W : CW;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        SHIFT,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [DATA_W-1:0] pout_q, pout_d;
    logic [CW-1:0]     bitCnt_q, bitCnt_d;
    logic [CW-1:0]     target_q, target_d;
    logic [HW-1:0]     hdrCnt_q, hdrCnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              wake_q, wake_d;
    logic              overrun_q, overrun_d;

    logic [DATA_W-1:0] shiftWord;
    logic [CW-1:0]     bitCntInc;
    logic [LEN_W-1:0]  lenNext;
    logic [TW-1:0]     lenWide;
    logic [CW-1:0]     hdrTarget;
    logic              lastBit;
    logic              lastHdrBit;

    // Datapath helpers: the word as it looks after taking the current
    // serial bit, the header value after taking it, and the payload
    // length that header selects (zero or oversized means full width).
    always_comb begin
        shiftWord  = sreg_q;
        bitCntInc  = bitCnt_q + CW'(1);
        lenNext    = LEN_W'({len_q, bus.serial_in});
        lenWide    = TW'(lenNext);
        hdrTarget  = CW'(DATA_W);
        lastBit    = (bitCntInc == target_q);
        lastHdrBit = (hdrCnt_q == HW'(LEN_W - 1));

        if (MSB_FIRST != 0) begin
            shiftWord = DATA_W'({sreg_q, bus.serial_in});
        end else begin
            for (int i = 0; i < DATA_W; i++) begin
                if (bitCnt_q == CW'(i)) begin
                    shiftWord[i] = bus.serial_in;
                end
            end
        end

        if ((lenWide != '0) && (lenWide <= TW'(DATA_W))) begin
            hdrTarget = CW'(lenWide);
        end
    end

    // Next-state and register updates for the frame sequencer.
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        pout_d    = pout_q;
        bitCnt_d  = bitCnt_q;
        target_d  = target_q;
        hdrCnt_d  = hdrCnt_q;
        len_d     = len_q;
        wake_d    = wake_q;
        overrun_d = overrun_q;

        case (state_q)
            IDLE: begin
                if (bus.rise) begin
                    sreg_d   = '0;
                    bitCnt_d = '0;
                    target_d = CW'(DATA_W);
                    hdrCnt_d = '0;
                    len_d    = '0;
                    state_d  = (VAR_LEN != 0) ? HEADER : SHIFT;
                end
            end
            HEADER: begin
                len_d    = lenNext;
                hdrCnt_d = hdrCnt_q + HW'(1);
                if (lastHdrBit) begin
                    target_d = hdrTarget;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                sreg_d   = shiftWord;
                bitCnt_d = bitCntInc;
                if (lastBit) begin
                    pout_d  = shiftWord;
                    wake_d  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.tx_ready) begin
                    wake_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.rise && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // State register with synchronous reset that discards any open frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            pout_q    <= '0;
            bitCnt_q  <= '0;
            target_q  <= CW'(DATA_W);
            hdrCnt_q  <= '0;
            len_q     <= '0;
            wake_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            pout_q    <= pout_d;
            bitCnt_q  <= bitCnt_d;
            target_q  <= target_d;
            hdrCnt_q  <= hdrCnt_d;
            len_q     <= len_d;
            wake_q    <= wake_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.wake_transmitter = wake_q;
    assign bus.pout             = pout_q;
    assign bus.bit_count        = bitCnt_q;
    assign bus.busy             = (state_q != IDLE);
    assign bus.overrun          = overrun_q;

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Bench for serial_frame_deserializer. Four configurations share one
// stimulus stream: fixed MSB-first, fixed LSB-first, 4-bit header MSB-first
// and a 5-bit-wide LSB-first receiver with a 3-bit header (exercises the
// clamp). Expected words come from a frame-level model of the stream.
module tb_serial_frame_deserializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic serialIn = 1'b0;
    logic riseIn = 1'b0;
    logic txReady = 1'b0;

    always #5 clk = ~clk;

    serial_frame_deserializer_if #(.DATA_W(8)) if0 ();
    serial_frame_deserializer_if #(.DATA_W(8)) if1 ();
    serial_frame_deserializer_if #(.DATA_W(8)) if2 ();
    serial_frame_deserializer_if #(.DATA_W(5)) if3 ();

    assign if0.serial_in = serialIn;
    assign if1.serial_in = serialIn;
    assign if2.serial_in = serialIn;
    assign if3.serial_in = serialIn;
    assign if0.rise = riseIn;
    assign if1.rise = riseIn;
    assign if2.rise = riseIn;
    assign if3.rise = riseIn;
    assign if0.tx_ready = txReady;
    assign if1.tx_ready = txReady;
    assign if2.tx_ready = txReady;
    assign if3.tx_ready = txReady;

    serial_frame_deserializer #(.DATA_W(8), .MSB_FIRST(1), .VAR_LEN(0), .LEN_W(4))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    serial_frame_deserializer #(.DATA_W(8), .MSB_FIRST(0), .VAR_LEN(0), .LEN_W(4))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    serial_frame_deserializer #(.DATA_W(8), .MSB_FIRST(1), .VAR_LEN(1), .LEN_W(4))
        u2 (.clk(clk), .rst(rst), .bus(if2));
    serial_frame_deserializer #(.DATA_W(5), .MSB_FIRST(0), .VAR_LEN(1), .LEN_W(3))
        u3 (.clk(clk), .rst(rst), .bus(if3));

    logic [31:0] poutObs [4];
    logic [31:0] cntObs  [4];
    logic        wakeObs [4];
    logic        busyObs [4];
    logic        ovrObs  [4];

    assign poutObs[0] = 32'(if0.pout);
    assign poutObs[1] = 32'(if1.pout);
    assign poutObs[2] = 32'(if2.pout);
    assign poutObs[3] = 32'(if3.pout);
    assign cntObs[0]  = 32'(if0.bit_count);
    assign cntObs[1]  = 32'(if1.bit_count);
    assign cntObs[2]  = 32'(if2.bit_count);
    assign cntObs[3]  = 32'(if3.bit_count);
    assign wakeObs[0] = if0.wake_transmitter;
    assign wakeObs[1] = if1.wake_transmitter;
    assign wakeObs[2] = if2.wake_transmitter;
    assign wakeObs[3] = if3.wake_transmitter;
    assign busyObs[0] = if0.busy;
    assign busyObs[1] = if1.busy;
    assign busyObs[2] = if2.busy;
    assign busyObs[3] = if3.busy;
    assign ovrObs[0]  = if0.overrun;
    assign ovrObs[1]  = if1.overrun;
    assign ovrObs[2]  = if2.overrun;
    assign ovrObs[3]  = if3.overrun;

    int vectors = 0;
    int miscompares = 0;

    bit          streamBits [64];
    logic [31:0] expWord  [4];
    logic [31:0] prevWord [4];
    int          expCnt   [4];
    int          doneEdge [4];
    int          payStart [4];
    bit          expOvr   [4];

    // Configuration table for the four receivers.
    function automatic int dwOf(input int d);
        return (d == 3) ? 5 : 8;
    endfunction

    function automatic bit msbOf(input int d);
        return (d == 0) || (d == 2);
    endfunction

    function automatic bit varOf(input int d);
        return d >= 2;
    endfunction

    function automatic int lwOf(input int d);
        return (d == 3) ? 3 : 4;
    endfunction

    // Fill the stream: first n bits in the order written in v, rest random.
    function automatic void loadStream(input logic [63:0] v, input int n);
        for (int i = 0; i < 64; i++) begin
            if (i < n) streamBits[i] = v[n-1-i];
            else       streamBits[i] = 1'($urandom);
        end
    endfunction

    // Frame-level expectation: header value, payload length, word and the
    // edge (counted after the accepting edge) on which the word completes.
    function automatic void modelFrame();
        for (int d = 0; d < 4; d++) begin
            int start = 0;
            int t = dwOf(d);
            int len = 0;
            logic [31:0] w = '0;
            if (varOf(d)) begin
                for (int i = 0; i < lwOf(d); i++) len = len * 2 + int'(streamBits[i]);
                start = lwOf(d);
                t = (len == 0 || len > dwOf(d)) ? dwOf(d) : len;
            end
            for (int i = 0; i < t; i++) begin
                if (msbOf(d)) w = w + (32'(streamBits[start+i]) << (t - 1 - i));
                else          w = w + (32'(streamBits[start+i]) << i);
            end
            expWord[d]  = w;
            expCnt[d]   = t;
            doneEdge[d] = start + t;
            payStart[d] = start;
        end
    endfunction

    // Drive one frame from the current stream and check every receiver on
    // every edge, then release it with tx_ready.
    task automatic runFrame(input bit txHigh, input int ovrEdge, input bit holdRise);
        int m = 0;
        modelFrame();
        for (int d = 0; d < 4; d++) if (doneEdge[d] > m) m = doneEdge[d];
        riseIn = 1'b1;
        txReady = txHigh;
        serialIn = 1'($urandom);
        @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            vectors++;
            if (busyObs[d] !== 1'b1 || wakeObs[d] !== 1'b0 || cntObs[d] !== 32'd0 || poutObs[d] !== prevWord[d]) begin
                miscompares++;
                $display("FAIL accept dut%0d: busy=%b wake=%b cnt=%0d pout=%h, want busy=1 wake=0 cnt=0 pout=%h",
                         d, busyObs[d], wakeObs[d], cntObs[d], poutObs[d], prevWord[d]);
            end
        end
        for (int e = 1; e <= m; e++) begin
            riseIn = holdRise || (e == ovrEdge);
            serialIn = streamBits[e-1];
            @(posedge clk);
            #1;
            for (int d = 0; d < 4; d++) begin
                bit ew;
                bit eb;
                int ec;
                logic [31:0] ep;
                if (riseIn && (!txHigh || e <= doneEdge[d] + 1)) expOvr[d] = 1'b1;
                ew = txHigh ? (e == doneEdge[d]) : (e >= doneEdge[d]);
                eb = txHigh ? (e <= doneEdge[d]) : 1'b1;
                ec = e - payStart[d];
                if (ec < 0) ec = 0;
                if (ec > expCnt[d]) ec = expCnt[d];
                ep = (e >= doneEdge[d]) ? expWord[d] : prevWord[d];
                vectors++;
                if (wakeObs[d] !== ew) begin
                    miscompares++;
                    $display("FAIL wake dut%0d edge%0d: got %b want %b", d, e, wakeObs[d], ew);
                end
                vectors++;
                if (busyObs[d] !== eb) begin
                    miscompares++;
                    $display("FAIL busy dut%0d edge%0d: got %b want %b", d, e, busyObs[d], eb);
                end
                vectors++;
                if (cntObs[d] !== 32'(ec)) begin
                    miscompares++;
                    $display("FAIL bit_count dut%0d edge%0d: got %0d want %0d", d, e, cntObs[d], ec);
                end
                vectors++;
                if (poutObs[d] !== ep) begin
                    miscompares++;
                    $display("FAIL pout dut%0d edge%0d: got %h want %h", d, e, poutObs[d], ep);
                end
                vectors++;
                if (ovrObs[d] !== expOvr[d]) begin
                    miscompares++;
                    $display("FAIL overrun dut%0d edge%0d: got %b want %b", d, e, ovrObs[d], expOvr[d]);
                end
            end
        end
        riseIn = 1'b0;
        txReady = 1'b1;
        serialIn = 1'($urandom);
        @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            vectors++;
            if (wakeObs[d] !== 1'b0 || busyObs[d] !== 1'b0 || poutObs[d] !== expWord[d] ||
                cntObs[d] !== 32'(expCnt[d]) || ovrObs[d] !== expOvr[d]) begin
                miscompares++;
                $display("FAIL release dut%0d: wake=%b busy=%b pout=%h cnt=%0d ovr=%b, want 0 0 %h %0d %b",
                         d, wakeObs[d], busyObs[d], poutObs[d], cntObs[d], ovrObs[d],
                         expWord[d], expCnt[d], expOvr[d]);
            end
            prevWord[d] = expWord[d];
        end
        txReady = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        riseIn = 1'b0;
        txReady = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 4; d++) begin
            expOvr[d] = 1'b0;
            prevWord[d] = '0;
            vectors++;
            if (wakeObs[d] !== 1'b0 || busyObs[d] !== 1'b0 || poutObs[d] !== 32'd0 ||
                cntObs[d] !== 32'd0 || ovrObs[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset dut%0d: wake=%b busy=%b pout=%h cnt=%0d ovr=%b, want all zero",
                         d, wakeObs[d], busyObs[d], poutObs[d], cntObs[d], ovrObs[d]);
            end
        end
    endtask

    task automatic test_fixed_pattern();
        loadStream(64'b10110010, 8);
        runFrame(1'b0, -1, 1'b0);
        vectors++;
        if (poutObs[0] !== 32'hB2) begin
            miscompares++;
            $display("FAIL msb_pattern: got %h want b2", poutObs[0]);
        end
        vectors++;
        if (poutObs[1] !== 32'h4D) begin
            miscompares++;
            $display("FAIL lsb_pattern: got %h want 4d", poutObs[1]);
        end
    endtask

    task automatic test_all_ones();
        loadStream(64'hFFFF_FFFF_FFFF_FFFF, 64);
        runFrame(1'b0, -1, 1'b0);
        vectors++;
        if (poutObs[0] !== 32'hFF || poutObs[1] !== 32'hFF) begin
            miscompares++;
            $display("FAIL all_ones: got %h/%h want ff/ff", poutObs[0], poutObs[1]);
        end
    endtask

    task automatic test_var_length();
        loadStream(64'b010111001, 9);
        runFrame(1'b0, -1, 1'b0);
        vectors++;
        if (poutObs[2] !== 32'h19 || cntObs[2] !== 32'd5) begin
            miscompares++;
            $display("FAIL var_len: pout=%h cnt=%0d want 19 5", poutObs[2], cntObs[2]);
        end
    endtask

    task automatic test_header_bounds();
        loadStream(64'b0000, 4);
        runFrame(1'b0, -1, 1'b0);
        vectors++;
        if (cntObs[2] !== 32'd8) begin
            miscompares++;
            $display("FAIL header_zero: cnt=%0d want 8", cntObs[2]);
        end
        loadStream(64'b1111, 4);
        runFrame(1'b0, -1, 1'b0);
        vectors++;
        if (cntObs[2] !== 32'd8 || cntObs[3] !== 32'd5) begin
            miscompares++;
            $display("FAIL header_clamp: cnt=%0d/%0d want 8/5", cntObs[2], cntObs[3]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            loadStream(64'd0, 0);
            runFrame(1'($urandom), -1, 1'b0);
        end
    endtask

    task automatic test_overrun();
        loadStream(64'd0, 0);
        runFrame(1'b1, 5, 1'b0);
        test_reset();
        loadStream(64'd0, 0);
        runFrame(1'b0, -1, 1'b1);
        test_reset();
    endtask

    task automatic test_mid_frame_reset();
        riseIn = 1'b1;
        @(posedge clk);
        #1;
        riseIn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            serialIn = 1'($urandom);
            @(posedge clk);
            #1;
        end
        test_reset();
        loadStream(64'b10100101, 8);
        runFrame(1'b0, -1, 1'b0);
        vectors++;
        if (poutObs[0] !== 32'hA5 || poutObs[1] !== 32'hA5) begin
            miscompares++;
            $display("FAIL after_reset: got %h/%h want a5/a5", poutObs[0], poutObs[1]);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++) begin
            loadStream(64'd0, 0);
            runFrame(1'b1, -1, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_pattern();
        test_all_ones();
        test_var_length();
        test_header_bounds();
        test_random();
        test_overrun();
        test_mid_frame_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_frame_deserializer.md
Name: serial_frame_deserializer

Overview:
Parametrised serial-to-parallel frame receiver. It is the next generation of the fixed 8-bit bit counter that wakes the transmitter.
- A `rise` pulse starts a frame. Payload bits are sampled from `serial_in`, one per clock.
- Adds configurable width, MSB/LSB-first order, an optional length-header mode, and a ready/valid handshake toward the transmitter.
- Adds a sticky overrun flag for start requests that arrive while a frame is in progress.

Parameters:
- DATA_W, 8: maximum payload bits and width of `pout`. Legal range 2..32.
- MSB_FIRST, 1: 1 = first payload bit lands in the most significant received position; 0 = first payload bit lands in `pout[0]`.
- VAR_LEN, 0: 1 = each frame starts with a LEN_W-bit length header, sent MSB first; 0 = fixed DATA_W payload.
- LEN_W, 4: header width. DATA_W must not exceed 2^LEN_W. Ignored when VAR_LEN = 0.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- serial_in  input  1  serial data, sampled on rising clk edges.
- rise  input  1  frame-start request, one or more cycles wide.
- tx_ready  input  1  transmitter accepts the held word.
- wake_transmitter  output  1  valid: `pout` holds a complete frame.
- pout  output  DATA_W  received word, right-justified.
- bit_count  output  CW = $clog2(DATA_W+1)  payload bits captured in the current or last frame.
- busy  output  1  high in any state other than IDLE.
- overrun  output  1  sticky: a `rise` was ignored.

Behaviour:
- Reset (`rst` = 1 at an edge):
  - state becomes IDLE; any partial frame is discarded.
  - wake_transmitter = 0, pout = 0, bit_count = 0, busy = 0, overrun = 0.
  - Reset has priority over every other input.
- IDLE:
  - `rise` = 1 at an edge: clear the shift register and bit_count.
  - target = DATA_W.
  - Next state is HEADER if VAR_LEN = 1, otherwise SHIFT.
  - `serial_in` is not sampled on the edge that accepts `rise`.
- HEADER (VAR_LEN = 1 only):
  - Sample LEN_W bits MSB first, one per edge, into the length register.
  - After the LEN_W-th bit, set target from the length value L:
    - L = 0 → DATA_W.
    - L > DATA_W → DATA_W (clamped).
    - otherwise → L.
  - Next state is SHIFT.
- SHIFT:
  - Sample `serial_in` every edge and increment bit_count.
  - MSB_FIRST = 1: shift register becomes {sreg[DATA_W-2:0], serial_in}.
  - MSB_FIRST = 0: `serial_in` is written to bit index bit_count.
  - Unfilled upper bits remain 0 in both orders.
  - On the edge that samples bit number target:
    - load `pout` with the completed word;
    - set wake_transmitter = 1;
    - go to HOLD.
- Latency, fixed mode: `rise` accepted at edge k; bits sampled at edges k+1..k+DATA_W; wake_transmitter is high from just after edge k+DATA_W.
- HOLD:
  - `pout`, bit_count and wake_transmitter stay stable.
  - `tx_ready` = 1 at an edge → IDLE, with wake_transmitter = 0 after that edge.
  - If `tx_ready` is already high on entry, wake_transmitter is high for exactly one cycle.
- `pout` changes only on frame completion or reset; it is never partially updated.
- bit_count advances live during SHIFT and holds its final value until the next accepted `rise`.
- Overrun:
  - `rise` = 1 at an edge in HEADER, SHIFT or HOLD is ignored and sets `overrun`.
  - This still applies when `rise` coincides with the `tx_ready` completion in HOLD; no restart occurs.
  - The frame in progress is unaffected.
  - `overrun` clears only on reset.
- A `rise` held high across a whole frame also sets `overrun`.
- `busy` = 1 in HEADER, SHIFT and HOLD.

Test Plan:
- DATA_W=8, MSB_FIRST=1, VAR_LEN=0; pulse `rise`, then send 1,0,1,1,0,0,1,0 with tx_ready=0 → pout=8'hB2, bit_count=8, wake_transmitter rises 8 edges after `rise` is accepted and holds until tx_ready=1, then drops one cycle later.
- Same stream with MSB_FIRST=0 → pout=8'h4D; with `serial_in` held at 1 → pout=8'hFF.
- VAR_LEN=1, LEN_W=4; header 0,1,0,1, then payload 1,1,0,0,1 → pout=8'h19, bit_count=5, wake_transmitter 9 edges after `rise`.
- VAR_LEN=1, header 0000 → 8 payload bits captured; header 1111 → clamped to 8 bits, bit_count=8.
- `rise` pulsed after the 4th payload bit, with tx_ready tied high → overrun=1, pout still correct, wake_transmitter high exactly one cycle, busy=0 afterwards.
- `rst`=1 for one edge after 3 payload bits → busy=0, pout=0, bit_count=0, overrun=0; the next `rise` with 8'hA5 yields pout=8'hA5.
